// File: rtl/mxv_sequencer_if.sv
// mxv_sequencer_if -- bundle of all non-clock signals of the matrix-vector
// sequencer.
//   Load port   : ld_mat_we, ld_vec_we, ld_addr, ld_data
//   Command     : start
//   MAC port    : mac_a, mac_b, mac_clr (to MAC), mac_acc (from MAC)
//   Result port : res_data, res_idx, res_valid (out), res_ready (in)
//   Status      : busy, done
// modport slave is the sequencer itself.
// modport master is the surrounding system, which loads the stores, issues
// start, hosts the MAC and consumes the results.
interface mxv_sequencer_if #(
  parameter int N      = 4,
  parameter int DW     = 8,
  parameter int DW_DBL = 16
);
  localparam int AW = $clog2(N*N);
  localparam int RW = $clog2(N);

  logic              ld_mat_we;
  logic              ld_vec_we;
  logic [AW-1:0]     ld_addr;
  logic [DW-1:0]     ld_data;
  logic              start;
  logic [DW-1:0]     mac_a;
  logic [DW-1:0]     mac_b;
  logic              mac_clr;
  logic [DW_DBL-1:0] mac_acc;
  logic [DW_DBL-1:0] res_data;
  logic [RW-1:0]     res_idx;
  logic              res_valid;
  logic              res_ready;
  logic              busy;
  logic              done;

  modport master (
    output ld_mat_we, ld_vec_we, ld_addr, ld_data, start, mac_acc, res_ready,
    input  mac_a, mac_b, mac_clr, res_data, res_idx, res_valid, busy, done
  );

  modport slave (
    input  ld_mat_we, ld_vec_we, ld_addr, ld_data, start, mac_acc, res_ready,
    output mac_a, mac_b, mac_clr, res_data, res_idx, res_valid, busy, done
  );
endinterface

// File: rtl/mxv_sequencer.sv
// mxv_sequencer -- sequences y = M*v through an external multiply-accumulate
// unit, one row at a time, and hands each row result out over a valid/ready
// port.
//   clk : rising-edge clock
//   rst : asynchronous, active-low reset (clears control, results and stores)
//   bus : mxv_sequencer_if.slave
//         ld_*      load the NxN matrix (row-major, addr = r*N+c) and the
//                   N-entry vector; accepted only while idle
//         start     begins a computation while idle
//         mac_*     operand/clear drive to the MAC and its accumulator return
//         res_*     row result, row index, valid/ready handshake
//         busy/done status; done pulses once after the last row is accepted
// Each row: CLEAR (1 cycle) -> RUN (N cycles) -> CAPTURE (1) -> OUT (>=1).
module mxv_sequencer #(
  parameter int N      = 4,
  parameter int DW     = 8,
  parameter int DW_DBL = 16
) (
  input  logic           clk,
  input  logic           rst,
  mxv_sequencer_if.slave bus
);
  localparam int AW = $clog2(N*N);
  localparam int RW = $clog2(N);

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, CAPTURE, OUT, DONE} state_t;

  state_t            state, state_nxt;
  logic [RW-1:0]     r, c;
  logic [DW-1:0]     mat [N*N];
  logic [DW-1:0]     vec [N];
  logic [AW-1:0]     rd_addr;
  logic              last_col, last_row, handshake;
  logic [DW-1:0]     mac_a, mac_b;
  logic              mac_clr;
  logic [DW_DBL-1:0] res_data;
  logic [RW-1:0]     res_idx;
  logic              res_valid, done;

  assign last_col  = (c == RW'(N-1));
  assign last_row  = (r == RW'(N-1));
  assign handshake = res_valid && bus.res_ready;
  assign rd_addr   = AW'(int'(r) * N + int'(c));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = CLEAR;
      CLEAR:   state_nxt = RUN;
      RUN:     if (last_col) state_nxt = CAPTURE;
      CAPTURE: state_nxt = OUT;
      OUT:     if (handshake) state_nxt = last_row ? DONE : CLEAR;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: the MAC only sees non-zero operands during RUN, so its
  // accumulator holds in every other state.
  always_comb begin
    mac_a   = '0;
    mac_b   = '0;
    mac_clr = 1'b0;
    case (state)
      CLEAR: mac_clr = 1'b1;
      RUN: begin
        mac_a = mat[rd_addr];
        mac_b = vec[c];
      end
      default: ;
    endcase
  end

  // Row / column counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r <= '0;
      c <= '0;
    end else begin
      case (state)
        IDLE:    if (bus.start) r <= '0;
        CLEAR:   c <= '0;
        RUN:     c <= c + 1'b1;
        OUT:     if (handshake && !last_row) r <= r + 1'b1;
        default: ;
      endcase
    end
  end

  // Result and done registers; mac_acc is complete during CAPTURE because the
  // last product was accumulated on the edge that left RUN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_data  <= '0;
      res_idx   <= '0;
      res_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= (state == DONE);
      if (state == CAPTURE) begin
        res_data  <= bus.mac_acc;
        res_idx   <= r;
        res_valid <= 1'b1;
      end else if (state == OUT && handshake) begin
        res_valid <= 1'b0;
      end
    end
  end

  // Operand stores: writable only while idle; out-of-range vector writes drop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N*N; i++) mat[i] <= '0;
      for (int i = 0; i < N; i++)   vec[i] <= '0;
    end else if (state == IDLE) begin
      if (bus.ld_mat_we) mat[bus.ld_addr] <= bus.ld_data;
      if (bus.ld_vec_we && bus.ld_addr < AW'(N)) vec[RW'(bus.ld_addr)] <= bus.ld_data;
    end
  end

  assign bus.mac_a     = mac_a;
  assign bus.mac_b     = mac_b;
  assign bus.mac_clr   = mac_clr;
  assign bus.res_data  = res_data;
  assign bus.res_idx   = res_idx;
  assign bus.res_valid = res_valid;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done;
endmodule
